// File: rtl/uvmt_apb_st_slv_mem.sv
// ---------------------------------------------------------------------------
// uvmt_apb_st_slv_mem
// APB completer memory model used as the reference responder in the APB VIP
// self-test. Word-addressed storage with a fixed number of wait states and
// PSLVERR on out-of-range or misaligned accesses.
//
// Optional feature macro: UVMT_APB_ST_SLV_MEM_PSTRB_EN
//   defined   : writes honour pstrb byte lanes; reads with pstrb != 0 error.
//   undefined : pstrb is ignored, writes update the full word.
//
// Ports:
//   clk       in   sole clock, rising edge
//   reset     in   synchronous active-high reset
//   psel      in   APB select
//   penable   in   APB enable (access phase)
//   pwrite    in   1 = write, 0 = read
//   paddr     in   byte address [ADDR_WIDTH]
//   pwdata    in   write data [DATA_WIDTH]
//   pstrb     in   byte strobes [DATA_WIDTH/8]
//   pprot     in   protection attributes, ignored
//   prdata    out  read data, valid on read completion
//   pready    out  high only in the completion cycle
//   pslverr   out  error, valid with pready
//   xfer_cnt  out  completed transfer count, wraps
//   err_cnt   out  completed errored transfer count, wraps
// ---------------------------------------------------------------------------
module uvmt_apb_st_slv_mem #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_WORDS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [15:0]             xfer_cnt,
  output logic [15:0]             err_cnt
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned LSB   = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam int unsigned CNT_W = 4;
  // One extra bit so BASE_ADDR + size cannot overflow at the top of the map.
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(BASE_ADDR) + (ADDR_WIDTH+1)'(NUM_WORDS * BYTES);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_setup;
  logic                    w_complete;

  logic                    r_write;
  logic                    r_err;
  logic [IDX_W-1:0]        r_idx;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_mem [NUM_WORDS];
  logic [15:0]             r_xfer_cnt;
  logic [15:0]             r_err_cnt;

  logic [ADDR_WIDTH-1:0]   w_off;
  logic [ADDR_WIDTH-1:0]   w_off_sh;
  logic                    w_below;
  logic                    w_above;
  logic                    w_misalign;
  logic                    w_err;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_unused;

  // Address decode for the setup phase.
  assign w_off      = paddr - BASE_ADDR;
  assign w_off_sh   = w_off >> LSB;
  assign w_idx      = w_off_sh[IDX_W-1:0];
  assign w_below    = (paddr < BASE_ADDR);
  assign w_above    = ({1'b0, paddr} >= LIMIT);
  assign w_misalign = ((paddr & ADDR_WIDTH'(BYTES - 1)) != '0);

`ifdef UVMT_APB_ST_SLV_MEM_PSTRB_EN
  logic [BYTES-1:0] r_strb;

  assign w_err    = w_below | w_above | w_misalign | (!pwrite && (pstrb != '0));
  assign w_unused = ^{pprot, w_off_sh};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_strb <= '0;
    end else if (w_setup) begin
      r_strb <= pstrb;
    end
  end
`else
  assign w_err    = w_below | w_above | w_misalign;
  assign w_unused = ^{pprot, pstrb, w_off_sh};
`endif

  // FSM state and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state; penable without a prior setup is ignored in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_setup     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (psel && !penable) begin
          w_state_nxt = S_ACCESS;
          w_cnt_nxt   = CNT_W'(WAIT_STATES);
          w_setup     = 1'b1;
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          w_state_nxt = S_IDLE;
        end else if (penable) begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            w_complete  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign pready   = w_complete;
  assign pslverr  = w_complete & r_err;
  assign prdata   = (w_complete && !r_write && !r_err) ? r_mem[r_idx] : '0;
  assign xfer_cnt = r_xfer_cnt;
  assign err_cnt  = r_err_cnt;

  // Transfer attributes captured on the setup edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else if (w_setup) begin
      r_write <= pwrite;
      r_err   <= w_err;
      r_idx   <= w_idx;
      r_wdata <= pwdata;
    end
  end

  // Storage; writes commit only on an error-free completion edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_WORDS); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_complete && r_write && !r_err) begin
`ifdef UVMT_APB_ST_SLV_MEM_PSTRB_EN
      for (int k = 0; k < int'(BYTES); k++) begin
        if (r_strb[k]) begin
          r_mem[r_idx][k*8 +: 8] <= r_wdata[k*8 +: 8];
        end
      end
`else
      r_mem[r_idx] <= r_wdata;
`endif
    end
  end

  // Completion and error counters, free-running wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_xfer_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (w_complete) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
      if (r_err) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uvmt_apb_st_slv_mem.sv
// ---------------------------------------------------------------------------
// tb_uvmt_apb_st_slv_mem
// Directed bench: three instances with WAIT_STATES 0, 3 and 2, each on its
// own APB bus, sharing clock and reset.
// ---------------------------------------------------------------------------
module tb_uvmt_apb_st_slv_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [31:0] paddr   [3];
  logic [31:0] pwdata  [3];
  logic [3:0]  pstrb   [3];
  logic [2:0]  pprot   [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];
  logic [15:0] xfer_cnt[3];
  logic [15:0] err_cnt [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uvmt_apb_st_slv_mem #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .NUM_WORDS  (16),
      .BASE_ADDR  (32'h0),
      .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 3 : 2)
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .psel    (psel[g]),
      .penable (penable[g]),
      .pwrite  (pwrite[g]),
      .paddr   (paddr[g]),
      .pwdata  (pwdata[g]),
      .pstrb   (pstrb[g]),
      .pprot   (pprot[g]),
      .prdata  (prdata[g]),
      .pready  (pready[g]),
      .pslverr (pslverr[g]),
      .xfer_cnt(xfer_cnt[g]),
      .err_cnt (err_cnt[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full APB transfer on bus d; checks latency, data, error, single-cycle pready.
  task automatic xfer(input int d, input string tag, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [31:0] exp_rdata,
                      input logic exp_err, input int exp_cyc);
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = wdata; pstrb[d] = strb;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    cyc = 2;
    @(negedge clk);
    while (pready[d] !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    rdata = prdata[d];
    err   = pslverr[d];
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    @(negedge clk);
    chk({tag, "_cycles"},  32'(cyc), 32'(exp_cyc));
    chk({tag, "_prdata"},  rdata, exp_rdata);
    chk({tag, "_pslverr"}, 32'(err), 32'(exp_err));
    chk({tag, "_pready_after"}, 32'(pready[d]), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
      paddr[i] = '0; pwdata[i] = '0; pstrb[i] = '0; pprot[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_pready%0d", i),  32'(pready[i]), 32'd0);
      chk($sformatf("rst_pslverr%0d", i), 32'(pslverr[i]), 32'd0);
      chk($sformatf("rst_prdata%0d", i),  prdata[i], 32'd0);
      chk($sformatf("rst_xfer%0d", i),    32'(xfer_cnt[i]), 32'd0);
      chk($sformatf("rst_err%0d", i),     32'(err_cnt[i]), 32'd0);
    end

    // Zero wait states: basic write/read
    xfer(0, "wr8", 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 2);
    xfer(0, "rd8", 1'b0, 32'h8, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 2);
    chk("xfer_after_rw", 32'(xfer_cnt[0]), 32'd2);

    // Errors: out of range, misaligned, errored read
    xfer(0, "wr40", 1'b1, 32'h40, 32'h12345678, 4'hF, 32'h0, 1'b1, 2);
    xfer(0, "wr6",  1'b1, 32'h6,  32'h12345678, 4'hF, 32'h0, 1'b1, 2);
    chk("err_after_bad_wr",  32'(err_cnt[0]), 32'd2);
    chk("xfer_after_bad_wr", 32'(xfer_cnt[0]), 32'd4);
    xfer(0, "rd40", 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b1, 2);
    xfer(0, "rd4",  1'b0, 32'h4,  32'h0, 4'h0, 32'h0, 1'b0, 2);
    xfer(0, "rd8b", 1'b0, 32'h8,  32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 2);
    xfer(0, "rd0",  1'b0, 32'h0,  32'h0, 4'h0, 32'h0, 1'b0, 2);

    // Last word in range
    xfer(0, "wr3c", 1'b1, 32'h3C, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 2);
    xfer(0, "rd3c", 1'b0, 32'h3C, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 2);
    chk("xfer_after_3c", 32'(xfer_cnt[0]), 32'd10);

    // psel+penable from IDLE without setup is ignored
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
    paddr[0] = 32'h10; pwdata[0] = 32'h5A5A5A5A;
    @(negedge clk);
    chk("viol_pready_c1", 32'(pready[0]), 32'd0);
    @(negedge clk);
    chk("viol_pready_c2", 32'(pready[0]), 32'd0);
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge clk);
    chk("viol_xfer", 32'(xfer_cnt[0]), 32'd10);

    // Byte strobes
    xfer(0, "wr10f", 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 2);
    xfer(0, "wr10s", 1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 1'b0, 2);
`ifdef UVMT_APB_ST_SLV_MEM_PSTRB_EN
    xfer(0, "rd10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hFFFFFFAA, 1'b0, 2);
`else
    xfer(0, "rd10", 1'b0, 32'h10, 32'h0, 4'h0, 32'h000000AA, 1'b0, 2);
`endif
    chk("xfer_final0", 32'(xfer_cnt[0]), 32'd13);
    chk("err_final0",  32'(err_cnt[0]),  32'd3);

    // Three wait states
    xfer(1, "ws3_rd0",  1'b0, 32'h0,  32'h0, 4'h0, 32'h0, 1'b0, 5);
    xfer(1, "ws3_wr20", 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 5);
    xfer(1, "ws3_rd20", 1'b0, 32'h20, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 5);
    chk("ws3_xfer", 32'(xfer_cnt[1]), 32'd3);

    // Master abort after one access cycle, two wait states
    @(posedge clk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
    paddr[2] = 32'h4; pwdata[2] = 32'h55555555; pstrb[2] = 4'hF;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(negedge clk);
    chk("abort_pready", 32'(pready[2]), 32'd0);
    @(posedge clk); #1;
    psel[2] = 1'b0; penable[2] = 1'b0;
    @(negedge clk);
    chk("abort_xfer", 32'(xfer_cnt[2]), 32'd0);
    xfer(2, "abort_rd4", 1'b0, 32'h4, 32'h0, 4'h0, 32'h0, 1'b0, 4);
    chk("abort_xfer_after_rd", 32'(xfer_cnt[2]), 32'd1);

    // Reset during the access phase of a write to 0xC
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 32'hC; pwdata[0] = 32'h11223344; pstrb[0] = 4'hF;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_pready",  32'(pready[0]), 32'd0);
    chk("mrst_pslverr", 32'(pslverr[0]), 32'd0);
    chk("mrst_prdata",  prdata[0], 32'd0);
    chk("mrst_xfer",    32'(xfer_cnt[0]), 32'd0);
    chk("mrst_err",     32'(err_cnt[0]), 32'd0);
    chk("mrst_xfer1",   32'(xfer_cnt[1]), 32'd0);
    xfer(0, "mrst_rdc", 1'b0, 32'hC, 32'h0, 4'h0, 32'h0, 1'b0, 2);
    xfer(0, "mrst_rd8", 1'b0, 32'h8, 32'h0, 4'h0, 32'h0, 1'b0, 2);
    chk("mrst_xfer_after", 32'(xfer_cnt[0]), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uvmt_apb_st_slv_mem.md
Name: uvmt_apb_st_slv_mem

Overview:
- APB completer (slave) memory model for the APB VIP self-test bench.
- Responds to transfers driven by the VIP master agent, and serves as the reference responder against which the VIP slave agent is compared.
- Word-addressed register array with programmable wait states and PSLVERR on out-of-range or misaligned access.
- Instantiated inside the self-test DUT wrapper, on the completer side of the APB interface.

Parameters:
- ADDR_WIDTH, 32, width of paddr.
- DATA_WIDTH, 32, width of pwdata/prdata; legal values 8, 16, 32.
- NUM_WORDS, 16, number of DATA_WIDTH-bit storage words; power of 2, at least 2.
- BASE_ADDR, 0, byte address of word 0; aligned to NUM_WORDS*DATA_WIDTH/8.
- WAIT_STATES, 0, number of access-phase cycles with pready=0 before completion; range 0..15.

Ports:
- clk  input  1  sole clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- psel  input  1  APB select.
- penable  input  1  APB enable (access phase).
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_WIDTH  byte address.
- pwdata  input  DATA_WIDTH  write data.
- pstrb  input  DATA_WIDTH/8  byte strobes; used only when the optional feature is enabled.
- pprot  input  3  accepted and ignored.
- prdata  output  DATA_WIDTH  read data.
- pready  output  1  transfer completion.
- pslverr  output  1  transfer error, valid with pready.
- xfer_cnt  output  16  number of completed transfers, wraps at 0xFFFF->0.
- err_cnt  output  16  number of completed transfers with pslverr=1, wraps.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: FSM=IDLE, wait counter=0, all memory words=0, xfer_cnt=0, err_cnt=0, prdata=0, pready=0, pslverr=0. Reset asserted mid-transfer aborts the transfer: no write commits and no counters increment.
- FSM has two states, IDLE and ACCESS.
  - IDLE: psel=1 and penable=0 (setup phase) -> ACCESS. On this edge, latch addr/write/wdata/strb, load wait counter with WAIT_STATES, and compute the error flag.
  - IDLE: psel=1 and penable=1 without a prior setup is a protocol violation. Ignore it and stay in IDLE with pready=0.
  - ACCESS: psel=0 (master abort) -> IDLE, no write commits, no counters increment.
  - ACCESS: psel=1, penable=1, counter!=0 -> decrement counter, pready=0.
  - ACCESS: psel=1, penable=1, counter==0 -> completion cycle, then IDLE on the next edge.
  - Back-to-back transfers: after completion, a new setup phase is accepted the next cycle from IDLE.
- pready, prdata and pslverr are combinational from state, counter and registered data; no combinational path from APB inputs except psel/penable qualifying pready.
  - pready=1 only in the completion cycle; 0 otherwise, including IDLE.
  - prdata = mem[index] on a read completion with no error, else 0.
  - pslverr=1 only on a completion cycle whose latched error flag is 1.
- Error flag is set when any of the following holds:
  - paddr < BASE_ADDR.
  - paddr >= BASE_ADDR + NUM_WORDS*DATA_WIDTH/8.
  - paddr not aligned to DATA_WIDTH/8.
- index = (paddr - BASE_ADDR) >> log2(DATA_WIDTH/8), truncated to log2(NUM_WORDS) bits.
- Write commit: on the completion-cycle edge, with pwrite=1 and error=0. Memory is updated on that edge and is readable by the next transfer.
- Latency: with WAIT_STATES=0 the transfer completes in the second cycle (setup + access). In general it takes 2+WAIT_STATES cycles.
- Counters: xfer_cnt increments on each completion; err_cnt increments on each completion with pslverr=1. Both wrap without saturation.
- Errored writes never modify memory. Errored reads return prdata=0.

Optional Feature:
- Macro: UVMT_APB_ST_SLV_MEM_PSTRB_EN.
- Defined: byte lane k of mem[index] is written only if pstrb[k]=1. A write with pstrb=0 completes with pready=1, pslverr=0 and leaves memory unchanged. A read with pstrb!=0 is an error (pslverr=1, prdata=0).
- Undefined: pstrb is ignored, every write updates the full word, and reads ignore pstrb.

Test Plan:
- Defaults; write 0xDEADBEEF to 0x8, then read 0x8 -> each transfer completes 2 cycles after setup, pready=1 for 1 cycle, prdata=0xDEADBEEF, pslverr=0, xfer_cnt=2.
- WAIT_STATES=3; read 0x0 after reset -> pready=0 for 3 access cycles, completes on the 5th cycle with prdata=0x00000000.
- Write 0x12345678 to 0x40 (out of range, NUM_WORDS=16), then write to misaligned 0x6 -> pslverr=1 on both, memory unchanged, err_cnt=2.
- Master drops psel after 1 access cycle with WAIT_STATES=2 during a write to 0x4 -> FSM returns to IDLE, a read of 0x4 returns 0, xfer_cnt unchanged.
- Assert reset during the access phase of a write to 0xC -> all outputs 0, the next read of 0xC returns 0, counters 0.
- With UVMT_APB_ST_SLV_MEM_PSTRB_EN: write 0xFFFFFFFF, then write 0x000000AA with pstrb=0b0001, then read -> 0xFFFFFFAA.
